// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops words from a show-ahead FIFO and serialises them as 8N1-style UART frames
module fifo_uart_tx #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DATA_BITS-1:0] fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q;
    logic [DW-1:0]        div_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [1:0]           stop_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 period_end;
    logic [DATA_BITS-1:0] shreg_d;

    assign period_end = (div_q == DW'(CLK_DIV - 1));
    assign shreg_d    = shreg_q >> 1;

    // Gated by rst_n so the FIFO is never popped while the block is held in reset.
    assign fifo_rd_en = rst_n && (state_q == IDLE) && en && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE || period_end) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (fifo_rd_en) begin
                        shreg_q <= fifo_dout;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (period_end) begin
                        tx_q      <= shreg_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (period_end) begin
                        shreg_q <= shreg_d;
                        if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                            tx_q       <= 1'b1;
                            stop_cnt_q <= '0;
                            state_q    <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            tx_q      <= shreg_d[0];
                        end
                    end
                end
                STOP: begin
                    if (period_end) begin
                        if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx (1 and 2 stop bits)
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, en2;
    logic [7:0] mem [0:63];
    logic [7:0] mem2[0:63];
    int         wptr = 0, rptr = 0, wptr2 = 0, rptr2 = 0;
    logic [7:0] fifo_dout, fifo_dout2;
    logic       fifo_empty, fifo_empty2;
    logic       fifo_rd_en, fifo_rd_en2;
    logic       tx, tx2, busy, busy2, tx_done, tx_done2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign fifo_empty  = (rptr == wptr);
    assign fifo_dout   = mem[rptr];
    assign fifo_empty2 = (rptr2 == wptr2);
    assign fifo_dout2  = mem2[rptr2];

    always @(posedge clk) begin
        if (fifo_rd_en)  rptr  <= rptr + 1;
        if (fifo_rd_en2) rptr2 <= rptr2 + 1;
    end

    fifo_uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    fifo_uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .fifo_dout(fifo_dout2), .fifo_empty(fifo_empty2),
        .fifo_rd_en(fifo_rd_en2), .tx(tx2), .busy(busy2), .tx_done(tx_done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles after the pop edge (CLK_DIV=4): start, 8 data bits LSB first, stop.
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        if (k < 4)  return 1'b0;
        if (k < 36) return b[(k - 4) / 4];
        return 1'b1;
    endfunction

    // Called at cycle 0 (just after the pop edge); returns at the tx_done cycle.
    task automatic frame_check(input logic [7:0] b, input bit two, input int drop_at);
        int L;
        L = two ? 44 : 40;
        for (int k = 0; k < L; k++) begin
            if (k == drop_at) begin
                en = 1'b0;
                mem[wptr] = 8'h11;
                wptr++;
            end
            chk($sformatf("tx_%0h_c%0d", b, k), two ? tx2 : tx, exp_tx(b, k));
            chk($sformatf("busy_%0h_c%0d", b, k), two ? busy2 : busy, 1'b1);
            chk($sformatf("rd_en_%0h_c%0d", b, k), two ? fifo_rd_en2 : fifo_rd_en, 1'b0);
            chk($sformatf("done_%0h_c%0d", b, k), two ? tx_done2 : tx_done, 1'b0);
            step();
        end
        chk($sformatf("done_end_%0h", b), two ? tx_done2 : tx_done, 1'b1);
        chk($sformatf("busy_end_%0h", b), two ? busy2 : busy, 1'b0);
        chk($sformatf("tx_end_%0h", b), two ? tx2 : tx, 1'b1);
    endtask

    initial begin
        // 1: reset with a non-empty FIFO and en high
        rst_n = 1'b0;
        en    = 1'b1;
        en2   = 1'b0;
        mem[0] = 8'hA5;
        wptr   = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_tx", tx, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rd_en", fifo_rd_en, 1'b0);
            chk("rst_done", tx_done, 1'b0);
        end

        // 2: single byte 0xA5 popped as soon as reset releases
        rst_n = 1'b1;
        #1;
        chk("a5_rd_en_pre", fifo_rd_en, 1'b1);
        step();
        frame_check(8'hA5, 1'b0, -1);
        chk("a5_rd_en_idle", fifo_rd_en, 1'b0);
        step();
        chk("a5_done_clear", tx_done, 1'b0);
        chk("a5_rptr", rptr, 1);

        // 3: back-to-back 0x00 then 0xFF, pops 41 cycles apart
        mem[1] = 8'h00;
        mem[2] = 8'hFF;
        wptr   = 3;
        #1;
        chk("b2b_rd_en_1", fifo_rd_en, 1'b1);
        step();
        frame_check(8'h00, 1'b0, -1);
        chk("b2b_rd_en_2", fifo_rd_en, 1'b1);
        step();
        frame_check(8'hFF, 1'b0, -1);
        chk("b2b_rd_en_after", fifo_rd_en, 1'b0);
        chk("b2b_rptr", rptr, 3);

        // 4: en low holds off the pop; raise en, then drop it mid-frame
        en = 1'b0;
        mem[3] = 8'h5A;
        wptr   = 4;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("en0_rd_en", fifo_rd_en, 1'b0);
            chk("en0_tx", tx, 1'b1);
            chk("en0_busy", busy, 1'b0);
        end
        en = 1'b1;
        #1;
        chk("en1_rd_en", fifo_rd_en, 1'b1);
        step();
        frame_check(8'h5A, 1'b0, 10);
        chk("endrop_rd_en", fifo_rd_en, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("endrop_idle_rd_en", fifo_rd_en, 1'b0);
            chk("endrop_idle_busy", busy, 1'b0);
        end
        chk("endrop_rptr", rptr, 4);

        // 5: asynchronous reset in the middle of the DATA phase
        en = 1'b1;
        #1;
        chk("mid_rd_en", fifo_rd_en, 1'b1);
        step();
        for (int i = 0; i < 15; i++) step();
        chk("mid_tx_before", tx, exp_tx(8'h11, 15));
        chk("mid_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_tx_async", tx, 1'b1);
        chk("mid_busy_async", busy, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_rd_en", fifo_rd_en, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_tx", tx, 1'b1);
        end
        chk("post_rst_rptr", rptr, 5);

        // 6: two stop bits, 0x3C then 0xC3 back-to-back with period 45
        en = 1'b0;
        mem2[0] = 8'h3C;
        mem2[1] = 8'hC3;
        wptr2   = 2;
        en2     = 1'b1;
        #1;
        chk("sb2_rd_en_1", fifo_rd_en2, 1'b1);
        step();
        frame_check(8'h3C, 1'b1, -1);
        chk("sb2_rd_en_2", fifo_rd_en2, 1'b1);
        step();
        frame_check(8'hC3, 1'b1, -1);
        chk("sb2_rd_en_after", fifo_rd_en2, 1'b0);
        step();
        chk("sb2_done_clear", tx_done2, 1'b0);
        chk("sb2_rptr", rptr2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
